sabertooth_packet_rx: RTL

- Receiver and decoder for the Sabertooth packetized-serial protocol; the opposite end of the motor module's uart_to_sabertooth transmit link.
- Deserialises 8N1 UART bytes and frames 4-byte packets: address, command, data, checksum.
- Validates address and checksum, then latches signed per-motor drive commands.
- Used as an in-fabric loopback checker for the motor module and as a Sabertooth model on the Speedy SoC.

---
 rtl/sabertooth_pkg.sv | 30 +++
 rtl/uart_rx_byte.sv | 107 ++++++++++
 rtl/sabertooth_packet_rx.sv | 125 ++++++++++++
 3 files changed

// File: rtl/sabertooth_pkg.sv
// Shared definitions for the Sabertooth packetized-serial link (receiver and transmitter).
package sabertooth_pkg;

   localparam logic [6:0] CMD_M1_FWD = 7'd0;
   localparam logic [6:0] CMD_M1_REV = 7'd1;
   localparam logic [6:0] CMD_M2_FWD = 7'd4;
   localparam logic [6:0] CMD_M2_REV = 7'd5;

   typedef enum logic [1:0] {
      PK_WAIT_ADDR,
      PK_GOT_ADDR,
      PK_GOT_CMD,
      PK_GOT_DATA
   } pkt_state_t;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_t;

   // Address bit 7 is always set, so only its low seven bits affect a mod-128 sum.
   function automatic logic [6:0] checksum7(input logic [6:0] addr_lo,
                                            input logic [6:0] cmd,
                                            input logic [6:0] data);
      return addr_lo + cmd + data;
   endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: 2-FF synchroniser, down-counting baud timer and byte FSM.
//   state    | meaning
//   RX_IDLE  | line idle, watching for a falling edge
//   RX_START | half-bit wait, then confirm the start bit
//   RX_DATA  | sampling 8 data bits, LSB first
//   RX_STOP  | sampling the stop bit
module uart_rx_byte
   import sabertooth_pkg::*;
#(
   parameter int DIV = 10
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       i_rx,
   output logic       o_byte_valid,
   output logic [7:0] o_byte_data,
   output logic       o_frame_err
);

   localparam int CW = $clog2(DIV);
   localparam logic [CW-1:0] FULL_LD = CW'(DIV - 1);
   localparam logic [CW-1:0] HALF_LD = CW'(DIV / 2 - 1);

   logic          r_sync1, r_sync2, r_sync3;
   rx_state_t     r_state, w_state_nxt;
   logic [CW-1:0] r_cnt, w_cnt_nxt;
   logic [2:0]    r_bit_idx;
   logic [7:0]    r_shift;
   logic          w_fall, w_shift, w_ok, w_err;

   always_comb begin
      w_fall      = r_sync3 & ~r_sync2;
      w_state_nxt = r_state;
      w_cnt_nxt   = (r_cnt == '0) ? r_cnt : r_cnt - CW'(1);
      w_shift     = 1'b0;
      w_ok        = 1'b0;
      w_err       = 1'b0;
      unique case (r_state)
         RX_IDLE: begin
            if (w_fall) begin
               w_state_nxt = RX_START;
               w_cnt_nxt   = HALF_LD;
            end
         end
         RX_START: begin
            if (r_cnt == '0) begin
               if (!r_sync2) begin
                  w_state_nxt = RX_DATA;
                  w_cnt_nxt   = FULL_LD;
               end else begin
                  w_state_nxt = RX_IDLE;
               end
            end
         end
         RX_DATA: begin
            if (r_cnt == '0) begin
               w_shift   = 1'b1;
               w_cnt_nxt = FULL_LD;
               if (r_bit_idx == 3'd7) w_state_nxt = RX_STOP;
            end
         end
         RX_STOP: begin
            // Leave mid-stop-bit so a back-to-back start edge is not missed.
            if (r_cnt == '0) begin
               w_ok        = r_sync2;
               w_err       = ~r_sync2;
               w_state_nxt = RX_IDLE;
            end
         end
         default: w_state_nxt = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= RX_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync1      <= 1'b1;
         r_sync2      <= 1'b1;
         r_sync3      <= 1'b1;
         r_cnt        <= '0;
         r_bit_idx    <= '0;
         r_shift      <= '0;
         o_byte_valid <= 1'b0;
         o_byte_data  <= '0;
         o_frame_err  <= 1'b0;
      end else begin
         r_sync1      <= i_rx;
         r_sync2      <= r_sync1;
         r_sync3      <= r_sync2;
         r_cnt        <= w_cnt_nxt;
         o_byte_valid <= w_ok;
         o_frame_err  <= w_err;
         if (r_state == RX_START) r_bit_idx <= '0;
         else if (w_shift)        r_bit_idx <= r_bit_idx + 3'd1;
         if (w_shift) r_shift <= {r_sync2, r_shift[7:1]};
         if (w_ok)    o_byte_data <= r_shift;
      end
   end

endmodule

// File: rtl/sabertooth_packet_rx.sv
// Sabertooth packet receiver: frames addr/cmd/data/checksum and latches signed motor commands.
//   state        | meaning
//   PK_WAIT_ADDR | waiting for a byte with bit7 set
//   PK_GOT_ADDR  | address held, expecting command
//   PK_GOT_CMD   | command held, expecting data
//   PK_GOT_DATA  | data held, expecting checksum
module sabertooth_packet_rx
   import sabertooth_pkg::*;
#(
   parameter int CLK_FREQ = 50000000,
   parameter int BAUD     = 9600,
   parameter int ADDRESS  = 128
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        uart_in,
   output logic        cmd_valid,
   output logic [6:0]  cmd_code,
   output logic [6:0]  cmd_data,
   output logic [7:0]  motor1_cmd,
   output logic [7:0]  motor2_cmd,
   output logic        frame_err,
   output logic        csum_err,
   output logic [15:0] pkt_count
);

   localparam int DIV = CLK_FREQ / BAUD;

   logic       w_byte_valid, w_frame_err;
   logic [7:0] w_byte_data;

   uart_rx_byte #(.DIV(DIV)) u_rx (
      .clk          (clk),
      .reset_n      (reset_n),
      .i_rx         (uart_in),
      .o_byte_valid (w_byte_valid),
      .o_byte_data  (w_byte_data),
      .o_frame_err  (w_frame_err)
   );

   assign frame_err = w_frame_err;

   pkt_state_t r_pk_state, w_pk_nxt;
   logic [7:0] r_addr;
   logic [6:0] r_cmd, r_data;
   logic       w_accept, w_csum_bad;
   logic [7:0] w_pos, w_neg;

   assign w_pos = {1'b0, r_data};
   assign w_neg = 8'd0 - w_pos;

   always_comb begin
      w_pk_nxt   = r_pk_state;
      w_accept   = 1'b0;
      w_csum_bad = 1'b0;
      if (w_frame_err) begin
         w_pk_nxt = PK_WAIT_ADDR;
      end else if (w_byte_valid) begin
         if (w_byte_data[7]) begin
            w_pk_nxt = PK_GOT_ADDR;
         end else begin
            unique case (r_pk_state)
               PK_WAIT_ADDR: w_pk_nxt = PK_WAIT_ADDR;
               PK_GOT_ADDR:  w_pk_nxt = PK_GOT_CMD;
               PK_GOT_CMD:   w_pk_nxt = PK_GOT_DATA;
               PK_GOT_DATA: begin
                  w_pk_nxt = PK_WAIT_ADDR;
                  // Foreign addresses are ignored outright, whatever their checksum.
                  if (r_addr == 8'(ADDRESS)) begin
                     if (w_byte_data[6:0] == checksum7(r_addr[6:0], r_cmd, r_data))
                        w_accept = 1'b1;
                     else
                        w_csum_bad = 1'b1;
                  end
               end
               default: w_pk_nxt = PK_WAIT_ADDR;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pk_state <= PK_WAIT_ADDR;
      end else begin
         r_pk_state <= w_pk_nxt;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_addr     <= '0;
         r_cmd      <= '0;
         r_data     <= '0;
         cmd_valid  <= 1'b0;
         csum_err   <= 1'b0;
         cmd_code   <= '0;
         cmd_data   <= '0;
         motor1_cmd <= '0;
         motor2_cmd <= '0;
         pkt_count  <= '0;
      end else begin
         cmd_valid <= w_accept;
         csum_err  <= w_csum_bad;
         if (w_byte_valid) begin
            if (w_byte_data[7])                 r_addr <= w_byte_data;
            else if (r_pk_state == PK_GOT_ADDR) r_cmd  <= w_byte_data[6:0];
            else if (r_pk_state == PK_GOT_CMD)  r_data <= w_byte_data[6:0];
         end
         if (w_accept) begin
            cmd_code  <= r_cmd;
            cmd_data  <= r_data;
            pkt_count <= pkt_count + 16'd1;
            case (r_cmd)
               CMD_M1_FWD: motor1_cmd <= w_pos;
               CMD_M1_REV: motor1_cmd <= w_neg;
               CMD_M2_FWD: motor2_cmd <= w_pos;
               CMD_M2_REV: motor2_cmd <= w_neg;
               default: ;
            endcase
         end
      end
   end

endmodule
